// File: rtl/cmd_queue_pkg.sv
// Shared definitions for the command-queue consumer: FSM state encoding,
// the slot valid marker, the location of the valid field inside a header
// word, and the slot-to-address mapping.
package cmd_queue_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR_RD   = 3'd1,
        ST_HDR_CHK  = 3'd2,
        ST_OUT      = 3'd3,
        ST_WORD_RD  = 3'd4,
        ST_LATCH    = 3'd5,
        ST_CLEAR    = 3'd6,
        ST_BACKOFF  = 3'd7
    } state_t;

    // Marker the producer writes into the top byte of a slot header.
    localparam logic [7:0]  VALID_BYTE    = 8'h80;
    localparam int unsigned VALID_FIELD_W = 32'd8;

    // Most significant bit of the valid field for a given word width.
    function automatic int unsigned valid_msb(input int unsigned width);
        return width - 32'd1;
    endfunction

    // Least significant bit of the valid field for a given word width.
    function automatic int unsigned valid_lsb(input int unsigned width);
        return width - VALID_FIELD_W;
    endfunction

    // Word address of the header of a slot.
    function automatic int unsigned slot_base(input int unsigned slot,
                                              input int unsigned slot_words);
        return slot * slot_words;
    endfunction

endpackage

// File: rtl/cmd_queue_reader.sv
// Consumer side of a BRAM-backed command ring. Polls the current slot header,
// streams all words of a valid slot on an AXI-Stream master, then frees the
// slot by zeroing the header's valid byte and moves to the next slot.
// Optional feature macro: CMD_QUEUE_READER_BACKOFF_EN adds a POLL_DELAY-cycle
// wait after every empty poll; without it an empty poll returns straight to IDLE.
module cmd_queue_reader
    import cmd_queue_pkg::*;
#(
    parameter int unsigned SIZE       = 32'd64,
    parameter int unsigned WIDTH      = 32'd64,
    parameter int unsigned SLOT_WORDS = 32'd4,
    parameter int unsigned POLL_DELAY = 32'd16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   enable,
    output logic                                   mem_en,
    output logic                                   mem_we,
    output logic [$clog2(SIZE)-1:0]                mem_addr,
    output logic [WIDTH-1:0]                       mem_din,
    input  logic [WIDTH-1:0]                       mem_dout,
    output logic                                   m_tvalid,
    input  logic                                   m_tready,
    output logic [WIDTH-1:0]                       m_tdata,
    output logic                                   m_tlast,
    output logic [$clog2(SIZE/SLOT_WORDS)-1:0]     rd_slot
);

    localparam int unsigned ADDR_W = $clog2(SIZE);
    localparam int unsigned SLOTS  = SIZE / SLOT_WORDS;
    localparam int unsigned SLOT_W = $clog2(SLOTS);
    localparam int unsigned IDX_W  = $clog2(SLOT_WORDS);
    localparam int unsigned VMSB   = valid_msb(WIDTH);
    localparam int unsigned VLSB   = valid_lsb(WIDTH);

`ifdef CMD_QUEUE_READER_BACKOFF_EN
    localparam bit BACKOFF_ON = 1'b1;
    localparam int unsigned CNT_W = $clog2(POLL_DELAY + 32'd1);
`else
    localparam bit BACKOFF_ON = 1'b0;
`endif

    // Reject configurations the slot layout or the backoff counter cannot support.
    if (((SIZE % SLOT_WORDS) != 32'd0) || (WIDTH < 32'd16) || (SLOT_WORDS < 32'd2) ||
        (BACKOFF_ON && (POLL_DELAY == 32'd0))) begin : g_cfg_error
        $error("cmd_queue_reader: unsupported parameter combination");
    end

    state_t                  state_r;
    logic [SLOT_W-1:0]       slot_r;
    logic [IDX_W-1:0]        idx_r;
    logic [VLSB-1:0]         hdr_low_r;
    logic                    mem_en_r;
    logic                    mem_we_r;
    logic [ADDR_W-1:0]       mem_addr_r;
    logic [WIDTH-1:0]        mem_din_r;
    logic                    m_tvalid_r;
    logic [WIDTH-1:0]        m_tdata_r;
    logic                    m_tlast_r;
`ifdef CMD_QUEUE_READER_BACKOFF_EN
    logic [CNT_W-1:0]        bo_cnt_r;
`endif

    logic [ADDR_W-1:0]       base_s;
    logic [IDX_W-1:0]        idx_next_s;
    logic [SLOT_W-1:0]       slot_next_s;
    logic                    hdr_valid_s;
    logic                    handshake_s;
    logic [WIDTH-1:0]        cleared_hdr_s;

    assign base_s        = ADDR_W'(slot_base(32'(slot_r), SLOT_WORDS));
    assign idx_next_s    = idx_r + IDX_W'(1);
    assign slot_next_s   = (slot_r == SLOT_W'(SLOTS - 32'd1)) ? {SLOT_W{1'b0}}
                                                              : slot_r + SLOT_W'(1);
    assign hdr_valid_s   = (mem_dout[VMSB:VLSB] == VALID_BYTE);
    assign handshake_s   = m_tvalid_r && m_tready;
    // Freed header keeps its payload bits so the producer can inspect it later.
    assign cleared_hdr_s = {{VALID_FIELD_W{1'b0}}, hdr_low_r};

    // Slot polling, streaming and clearing state machine; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            slot_r     <= {SLOT_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            hdr_low_r  <= {VLSB{1'b0}};
            mem_en_r   <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_addr_r <= {ADDR_W{1'b0}};
            mem_din_r  <= {WIDTH{1'b0}};
            m_tvalid_r <= 1'b0;
            m_tdata_r  <= {WIDTH{1'b0}};
            m_tlast_r  <= 1'b0;
`ifdef CMD_QUEUE_READER_BACKOFF_EN
            bo_cnt_r   <= {CNT_W{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    mem_we_r <= 1'b0;
                    if (enable) begin
                        mem_en_r   <= 1'b1;
                        mem_addr_r <= base_s;
                        state_r    <= ST_HDR_RD;
                    end else begin
                        mem_en_r   <= 1'b0;
                    end
                end
                ST_HDR_RD: begin
                    mem_en_r <= 1'b0;
                    state_r  <= ST_HDR_CHK;
                end
                ST_HDR_CHK: begin
                    if (hdr_valid_s) begin
                        hdr_low_r  <= mem_dout[VLSB-1:0];
                        m_tdata_r  <= mem_dout;
                        m_tvalid_r <= 1'b1;
                        m_tlast_r  <= 1'b0;
                        idx_r      <= {IDX_W{1'b0}};
                        state_r    <= ST_OUT;
                    end else begin
`ifdef CMD_QUEUE_READER_BACKOFF_EN
                        bo_cnt_r   <= {CNT_W{1'b0}};
                        state_r    <= ST_BACKOFF;
`else
                        state_r    <= ST_IDLE;
`endif
                    end
                end
                ST_OUT: begin
                    if (handshake_s) begin
                        m_tvalid_r <= 1'b0;
                        m_tlast_r  <= 1'b0;
                        mem_en_r   <= 1'b1;
                        if (m_tlast_r) begin
                            mem_we_r   <= 1'b1;
                            mem_addr_r <= base_s;
                            mem_din_r  <= cleared_hdr_s;
                            state_r    <= ST_CLEAR;
                        end else begin
                            idx_r      <= idx_next_s;
                            mem_addr_r <= base_s + ADDR_W'(idx_next_s);
                            state_r    <= ST_WORD_RD;
                        end
                    end else begin
                        state_r <= ST_OUT;
                    end
                end
                ST_WORD_RD: begin
                    mem_en_r <= 1'b0;
                    state_r  <= ST_LATCH;
                end
                ST_LATCH: begin
                    m_tdata_r  <= mem_dout;
                    m_tvalid_r <= 1'b1;
                    m_tlast_r  <= (idx_r == IDX_W'(SLOT_WORDS - 32'd1));
                    state_r    <= ST_OUT;
                end
                ST_CLEAR: begin
                    mem_en_r <= 1'b0;
                    mem_we_r <= 1'b0;
                    slot_r   <= slot_next_s;
                    state_r  <= ST_IDLE;
                end
                ST_BACKOFF: begin
`ifdef CMD_QUEUE_READER_BACKOFF_EN
                    if (bo_cnt_r == CNT_W'(POLL_DELAY - 32'd1)) begin
                        bo_cnt_r <= {CNT_W{1'b0}};
                        state_r  <= ST_IDLE;
                    end else begin
                        bo_cnt_r <= bo_cnt_r + CNT_W'(1);
                    end
`else
                    state_r <= ST_IDLE;
`endif
                end
                default: begin
                    mem_en_r <= 1'b0;
                    mem_we_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_en   = mem_en_r;
    assign mem_we   = mem_we_r;
    assign mem_addr = mem_addr_r;
    assign mem_din  = mem_din_r;
    assign m_tvalid = m_tvalid_r;
    assign m_tdata  = m_tdata_r;
    assign m_tlast  = m_tlast_r;
    assign rd_slot  = slot_r;

endmodule

// File: tb/tb_cmd_queue_reader.sv
// Directed bench for cmd_queue_reader with a READ_FIRST, 1-cycle-latency
// dual-port memory model; the second port acts as the producer.
module tb_cmd_queue_reader;

`ifdef CMD_QUEUE_READER_BACKOFF_EN
    localparam int POLL_PERIOD = 3 + 16;
`else
    localparam int POLL_PERIOD = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        mem_en;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [63:0] mem_din;
    logic [63:0] mem_dout;
    logic        m_tvalid;
    logic        m_tready;
    logic [63:0] m_tdata;
    logic        m_tlast;
    logic [3:0]  rd_slot;

    logic        p_we;
    logic [5:0]  p_addr;
    logic [63:0] p_din;
    logic [63:0] mem [0:63];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cmd_queue_reader dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast),
        .rd_slot  (rd_slot)
    );

    // Dual-port memory: DUT port is READ_FIRST, producer port write-only.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_dout <= mem[mem_addr];
            if (mem_we) mem[mem_addr] <= mem_din;
        end
        if (p_we) mem[p_addr] <= p_din;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] word_val(input int s, input int k);
        logic [63:0] v;
        v = 64'(s * 256 + k + 1);
        if (k == 0) v[63:56] = 8'h80;
        return v;
    endfunction

    task automatic pwrite(input int a, input logic [63:0] d);
        p_we = 1'b1; p_addr = 6'(a); p_din = d;
        @(negedge clk);
        p_we = 1'b0;
    endtask

    task automatic load_slot(input int s);
        for (int k = 0; k < 4; k++) pwrite(s * 4 + k, word_val(s, k));
    endtask

    task automatic wait_rd(output int n, output int tv);
        n = 0; tv = 0;
        do begin
            @(negedge clk);
            n++;
            if (m_tvalid) tv++;
        end while (!(mem_en && !mem_we) && n < 60);
        if (!(mem_en && !mem_we)) n = -1;
    endtask

    task automatic expect_beat(input string tag, input logic [63:0] d, input logic l);
        int n = 0;
        while (!(m_tvalid && m_tready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (m_tvalid && m_tready) begin
            check({tag, "_data"}, m_tdata, d);
            check({tag, "_last"}, 64'(m_tlast), 64'(l));
        end else begin
            check({tag, "_timeout_tvalid"}, 64'(m_tvalid && m_tready), 64'd1);
        end
        @(negedge clk);
    endtask

    task automatic expect_clear(input string tag, input logic [5:0] a, input logic [63:0] d);
        check({tag, "_wr"}, 64'(mem_en && mem_we), 64'd1);
        check({tag, "_addr"}, 64'(mem_addr), 64'(a));
        check({tag, "_din"}, mem_din, d);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, tv, bad, memc;
        rst = 1'b1; enable = 1'b0; m_tready = 1'b1;
        p_we = 1'b0; p_addr = 6'd0; p_din = 64'd0;
        @(negedge clk);
        for (int a = 0; a < 64; a++) pwrite(a, 64'd0);
        load_slot(0);

        // Reset values
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tlast", 64'(m_tlast), 64'd0);
        check("rst_tdata", m_tdata, 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_din", mem_din, 64'd0);
        check("rst_rd_slot", 64'(rd_slot), 64'd0);

        // T1: one valid slot, header latency, 4 beats, clear
        rst = 1'b0; enable = 1'b1;
        wait_rd(n, tv);
        check("t1_hdr_addr", 64'(mem_addr), 64'd0);
        @(negedge clk);
        check("t1_tvalid_t1", 64'(m_tvalid), 64'd0);
        @(negedge clk);
        check("t1_tvalid_t2", 64'(m_tvalid), 64'd1);
        expect_beat("t1_w0", 64'h8000_0000_0000_0001, 1'b0);
        expect_beat("t1_w1", 64'h2, 1'b0);
        expect_beat("t1_w2", 64'h3, 1'b0);
        expect_beat("t1_w3", 64'h4, 1'b1);
        expect_clear("t1_clr", 6'd0, 64'h1);
        @(negedge clk);
        check("t1_rd_slot", 64'(rd_slot), 64'd1);
        check("t1_mem0", mem[0], 64'h1);

        // T2: empty polling of slot 1
        wait_rd(n, tv);
        check("t2_addr0", 64'(mem_addr), 64'd4);
        wait_rd(n, tv);
        check("t2_period1", 64'(n), 64'(POLL_PERIOD));
        check("t2_addr1", 64'(mem_addr), 64'd4);
        check("t2_tvalid1", 64'(tv), 64'd0);
        wait_rd(n, tv);
        check("t2_period2", 64'(n), 64'(POLL_PERIOD));
        check("t2_tvalid2", 64'(tv), 64'd0);
        enable = 1'b0;
        repeat (30) @(negedge clk);
        check("t2_rd_slot", 64'(rd_slot), 64'd1);

        // T3: header held under backpressure
        load_slot(1);
        m_tready = 1'b0; enable = 1'b1;
        n = 0;
        while (!m_tvalid && n < 20) begin @(negedge clk); n++; end
        enable = 1'b0;
        check("t3_hdr_tvalid", 64'(m_tvalid), 64'd1);
        check("t3_hdr_data", m_tdata, word_val(1, 0));
        bad = 0; memc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_tdata !== word_val(1, 0) || m_tvalid !== 1'b1 || m_tlast !== 1'b0) bad++;
            if (mem_en) memc++;
        end
        check("t3_stable", 64'(bad), 64'd0);
        check("t3_no_read", 64'(memc), 64'd0);
        m_tready = 1'b1;
        for (int k = 0; k < 4; k++)
            expect_beat($sformatf("t3_w%0d", k), word_val(1, k), k == 3);
        expect_clear("t3_clr", 6'd4, 64'h101);
        @(negedge clk);
        check("t3_rd_slot", 64'(rd_slot), 64'd2);

        // T4: all 16 slots valid, wrap back to slot 0
        rst = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 16; s++) load_slot(s);
        check("t4_rst_slot", 64'(rd_slot), 64'd0);
        rst = 1'b0; enable = 1'b1;
        for (int s = 0; s < 16; s++)
            for (int k = 0; k < 4; k++)
                expect_beat($sformatf("t4_s%0d_w%0d", s, k), word_val(s, k), k == 3);
        expect_clear("t4_clr15", 6'd60, 64'h0F01);
        wait_rd(n, tv);
        enable = 1'b0;
        check("t4_next_rd_gap", 64'(n), 64'd2);
        check("t4_next_rd_addr", 64'(mem_addr), 64'd0);
        tv = 0;
        repeat (5) begin @(negedge clk); if (m_tvalid) tv++; end
        check("t4_empty_no_tvalid", 64'(tv), 64'd0);
        check("t4_rd_slot", 64'(rd_slot), 64'd0);

        // T5: reset while beat 2 waits
        rst = 1'b1;
        repeat (2) @(negedge clk);
        load_slot(0);
        load_slot(1);
        rst = 1'b0; enable = 1'b1; m_tready = 1'b1;
        expect_beat("t5_w0", word_val(0, 0), 1'b0);
        m_tready = 1'b0;
        n = 0;
        while (!m_tvalid && n < 10) begin @(negedge clk); n++; end
        check("t5_w1_data", m_tdata, word_val(0, 1));
        rst = 1'b1; enable = 1'b0;
        @(negedge clk);
        check("t5_tvalid_drop", 64'(m_tvalid), 64'd0);
        check("t5_rd_slot", 64'(rd_slot), 64'd0);
        check("t5_hdr_kept", 64'(mem[0][63:56]), 64'h80);

        // T6: enable dropped after the header beat
        @(negedge clk);
        rst = 1'b0; enable = 1'b1; m_tready = 1'b1;
        expect_beat("t6_w0", word_val(0, 0), 1'b0);
        enable = 1'b0;
        for (int k = 1; k < 4; k++)
            expect_beat($sformatf("t6_w%0d", k), word_val(0, k), k == 3);
        expect_clear("t6_clr", 6'd0, 64'h1);
        memc = 0; tv = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_en) memc++;
            if (m_tvalid) tv++;
        end
        check("t6_no_poll", 64'(memc), 64'd0);
        check("t6_no_tvalid", 64'(tv), 64'd0);
        check("t6_rd_slot", 64'(rd_slot), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmd_queue_reader.md
# cmd_queue_reader

Consumer side of a BRAM-backed command queue. The block drives one port of a `dual_port_mem_wrapper` instance configured READ_FIRST with 1-cycle read latency, while the producer owns the other port. It polls fixed-size slots for a valid header, streams each valid slot out on an AXI-Stream master, then frees the slot by clearing its valid byte. The read pointer wraps through the ring.

## Interface
- `SIZE`, 64: memory depth in words; must be a multiple of `SLOT_WORDS`.
- `WIDTH`, 64: word width; must be at least 16.
- `SLOT_WORDS`, 4: words per slot, header included; must be 2 or more.
- `POLL_DELAY`, 16: idle cycles between polls of an empty slot; used only with the backoff macro.
- `clk` input 1: single clock for the whole block.
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: allows new polls; sampled only in IDLE.
- `mem_en` output 1: memory port enable.
- `mem_we` output 1: memory port write enable.
- `mem_addr` output `$clog2(SIZE)`: word address.
- `mem_din` output WIDTH: write data.
- `mem_dout` input WIDTH: read data, valid 1 cycle after `mem_en` with `mem_we` low.
- `m_tvalid` output 1, `m_tready` input 1, `m_tdata` output WIDTH, `m_tlast` output 1: stream master.
- `rd_slot` output `$clog2(SIZE/SLOT_WORDS)`: current slot index.

## Operation
- A slot is valid when the header bits `[WIDTH-1:WIDTH-8]` equal 8'h80. Any other value means empty.
- States and transitions:
  - IDLE: if `enable`, go to HDR_RD.
  - HDR_RD: assert `mem_en` with `mem_addr` = slot base. Go to HDR_CHK.
  - HDR_CHK: sample `mem_dout`.
    - Valid: store the header, load it into `m_tdata`, set `m_tvalid`, word index = 0, go to OUT.
    - Empty: go to BACKOFF if the macro is defined, otherwise IDLE.
  - OUT: hold `m_tvalid`/`m_tdata`/`m_tlast` until `m_tready`.
    - On the handshake of the last word, go to CLEAR.
    - Otherwise increment the word index and go to WORD_RD.
  - WORD_RD: `mem_en`, `mem_addr` = base + index. Go to LATCH.
  - LATCH: `m_tdata` <= `mem_dout`, `m_tvalid` <= 1, `m_tlast` <= (index == `SLOT_WORDS`-1). Go to OUT.
  - CLEAR: `mem_en`=`mem_we`=1, `mem_addr` = base, `mem_din` = stored header with bits `[WIDTH-1:WIDTH-8]` = 0. Advance the slot and go to IDLE.
  - BACKOFF: count `POLL_DELAY` cycles, then go to IDLE.
- Slot advance: `rd_slot` + 1, wrapping from `SIZE/SLOT_WORDS`-1 to 0. The slot only advances after CLEAR. Empty polls never advance it.
- The stream carries all `SLOT_WORDS` words including the header. `m_tlast` is set on the final word only.
- Deasserting `enable` mid-slot has no effect: the slot streams fully and is cleared, then the block stops in IDLE.
- `m_tdata`, `m_tlast` and `m_tvalid` are stable while `m_tvalid && !m_tready`.
- `mem_en` is low in every state not listed above as asserting it.

## Timing
- Reset values: state IDLE, `rd_slot` 0, and `m_tvalid`, `m_tlast`, `m_tdata`, `mem_en`, `mem_we`, `mem_addr`, `mem_din` all 0. The backoff counter is also 0.
- `rst` mid-slot aborts immediately: the slot is not cleared and `m_tvalid` drops the next cycle. This is the only allowed `m_tvalid` drop without a handshake.
- Header read issued at cycle t gives header `m_tvalid` at t+2.
- Each later word: handshake at c, then read at c+1 and `m_tvalid` at c+3.
- Clear write occurs 1 cycle after the last handshake. The next header read follows 2 cycles after the clear write with `enable` high.
- Empty poll period: 3 cycles without the macro, 3+`POLL_DELAY` cycles with it.
- A producer write to the same address in the same cycle as the clear yields an undefined memory result. Producers must not rewrite an un-cleared slot.

## Configuration
- `CMD_QUEUE_READER_BACKOFF_EN`:
  - Defined: the BACKOFF state and its counter of `$clog2(POLL_DELAY+1)` bits exist, and an empty poll waits `POLL_DELAY` cycles.
  - Undefined: no counter; HDR_CHK on an empty slot goes directly to IDLE.

## Structure
- Shared package `cmd_queue_pkg`: the state enum, `VALID_BYTE` = 8'h80, the valid-field bit positions, and a `slot_base(slot)` function.
- No sub-module; the memory itself stays outside this block.

## Test plan
- Memory preloaded with slot 0 = {80_..01, 2, 3, 4}, `m_tready`=1 → 4 beats 0x8000..01, 2, 3, 4; `m_tlast` on beat 4; clear write at addr 0 with top byte 0; `rd_slot`=1.
- All slots empty, `enable`=1, macro off → `mem_en` pulses every 3 cycles at addr 0; no `m_tvalid`. Macro on with `POLL_DELAY`=16 → every 19 cycles.
- Header beat held with `m_tready`=0 for 10 cycles → `m_tdata` stable; no further memory read until the handshake.
- All 16 slots valid → 16 packets in order; the 17th poll is at addr 0 and finds it empty.
- `rst` asserted while beat 2 waits → next cycle `m_tvalid`=0 and `rd_slot`=0; slot 0 header still 0x80 in memory.
- `enable` dropped after the slot-0 header beat → slot 0 completes and clears; no poll of slot 1.
